// File: rtl/agc_core_param_if.sv
// Sample/control bundle between the AGC core and its source/sink.
// The master side drives samples and settings, the slave side is the core.
interface agc_core_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned GAIN_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] target;
    logic [1:0]        mode;
    logic [GAIN_W-1:0] fixed_gain;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              clipped;
    logic [GAIN_W-1:0] gain;
    logic [1:0]        agc_state;

    modport master (
        output in_valid, in_data, target, mode, fixed_gain,
        input  out_valid, out_data, clipped, gain, agc_state
    );

    modport slave (
        input  in_valid, in_data, target, mode, fixed_gain,
        output out_valid, out_data, clipped, gain, agc_state
    );
endinterface

// File: rtl/agc_core_param.sv
// Parametrised AGC: registers a sample, scales it by an adaptive gain with
// saturation, then updates envelope and gain FSM one enabled edge later.
module agc_core_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned GAIN_W    = 8,
    parameter int unsigned FRAC      = 4,
    parameter int unsigned ENV_SHIFT = 4,
    parameter int unsigned HOLD_LEN  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    agc_core_param_if.slave bus
);
    localparam int unsigned PROD_W = DATA_W + GAIN_W + 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_LEN + 1);
    localparam logic signed [PROD_W-1:0] MAX_V = PROD_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] MIN_V = ~MAX_V;
    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1 << FRAC);
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;
    localparam logic [1:0] MODE_FROZEN = 2'b11;

    typedef enum logic [1:0] {
        ST_SETTLED = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } agc_state_e;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              clipped_q, clipped_d;
    logic [1:0]        out_mode_q, out_mode_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [DATA_W-1:0] env_q, env_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    agc_state_e        state_q, state_d;

    logic signed [PROD_W-1:0] samp_ext, gain_ext, prod, shifted;
    logic [DATA_W-1:0]        scaled;
    logic                     scaled_clip;
    logic [DATA_W-1:0]        abs_val, decayed, env_next, rel_thr;

    // Stage 2 datapath: signed multiply, floor shift, clamp
    always_comb begin
        samp_ext    = PROD_W'($signed(s1_data_q));
        gain_ext    = $signed(PROD_W'(gain_q));
        prod        = samp_ext * gain_ext;
        shifted     = prod >>> FRAC;
        scaled      = DATA_W'(shifted);
        scaled_clip = 1'b0;
        if (s1_mode_q == MODE_BYPASS) begin
            scaled = s1_data_q;
        end else if (shifted > MAX_V) begin
            scaled      = DATA_W'(MAX_V);
            scaled_clip = 1'b1;
        end else if (shifted < MIN_V) begin
            scaled      = DATA_W'(MIN_V);
            scaled_clip = 1'b1;
        end
    end

    // Envelope follower on the registered output; |-2^(N-1)| wraps to 2^(N-1) unsigned
    always_comb begin
        abs_val  = out_data_q[DATA_W-1] ? (~out_data_q) + DATA_W'(1) : out_data_q;
        decayed  = env_q - (env_q >> ENV_SHIFT);
        env_next = (abs_val > decayed) ? abs_val : decayed;
        rel_thr  = bus.target - (bus.target >> 3);
    end

    always_comb begin
        s1_valid_d  = bus.in_valid;
        s1_data_d   = s1_data_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = s1_valid_q;
        out_data_d  = out_data_q;
        clipped_d   = clipped_q;
        out_mode_d  = out_mode_q;
        gain_d      = gain_q;
        env_d       = env_q;
        hold_d      = hold_q;
        state_d     = state_q;

        if (bus.in_valid) begin
            s1_data_d = bus.in_data;
            s1_mode_d = bus.mode;
        end

        if (s1_valid_q) begin
            out_data_d = scaled;
            clipped_d  = scaled_clip;
            out_mode_d = s1_mode_q;
        end

        // Control step for the sample presented on the output last cycle
        if (out_valid_q) begin
            env_d = env_next;
            case (out_mode_q)
                MODE_FIXED: gain_d = bus.fixed_gain;
                MODE_AUTO, MODE_FROZEN: begin
                    if (env_next > bus.target) begin
                        hold_d  = HOLD_W'(HOLD_LEN);
                        state_d = ST_ATTACK;
                        if (out_mode_q == MODE_AUTO)
                            gain_d = (gain_q > GAIN_W'(1)) ? gain_q - GAIN_W'(1) : GAIN_W'(1);
                    end else if (hold_q != '0) begin
                        hold_d  = hold_q - HOLD_W'(1);
                        state_d = ST_HOLD;
                    end else if (env_next < rel_thr) begin
                        state_d = ST_RELEASE;
                        if (out_mode_q == MODE_AUTO && gain_q != GAIN_MAX)
                            gain_d = gain_q + GAIN_W'(1);
                    end else begin
                        state_d = ST_SETTLED;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_mode_q   <= MODE_BYPASS;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            clipped_q   <= 1'b0;
            out_mode_q  <= MODE_BYPASS;
            gain_q      <= UNITY;
            env_q       <= '0;
            hold_q      <= '0;
            state_q     <= ST_SETTLED;
        end else if (clk_enable) begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            clipped_q   <= clipped_d;
            out_mode_q  <= out_mode_d;
            gain_q      <= gain_d;
            env_q       <= env_d;
            hold_q      <= hold_d;
            state_q     <= state_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.clipped   = clipped_q;
    assign bus.gain      = gain_q;
    assign bus.agc_state = state_q;
endmodule

// File: tb/tb_agc_core_param.sv
// Randomised and directed bench for agc_core_param against an integer
// arithmetic reference model of the sample pipeline and gain control.
module tb_agc_core_param;
    localparam int DATA_W    = 8;
    localparam int GAIN_W    = 8;
    localparam int FRAC      = 4;
    localparam int ENV_SHIFT = 4;
    localparam int HOLD_LEN  = 16;
    localparam int SMAX      = (1 << (DATA_W - 1)) - 1;
    localparam int SMIN      = -(1 << (DATA_W - 1));
    localparam int GMAX      = (1 << GAIN_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;

    agc_core_param_if #(.DATA_W(DATA_W), .GAIN_W(GAIN_W)) bus ();

    agc_core_param #(
        .DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC(FRAC),
        .ENV_SHIFT(ENV_SHIFT), .HOLD_LEN(HOLD_LEN)
    ) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, all plain integers
    int m_gain, m_env, m_hold, m_state;
    bit p1_v;
    int p1_d, p1_m;
    bit o_v;
    int o_d, o_c, o_m;
    bit new_out;

    int out_log[$];
    int clip_log[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_scaled(input int s, input int g);
        int p, q;
        p = s * g;
        q = p / (1 << FRAC);
        if (p < 0 && q * (1 << FRAC) != p) q = q - 1;
        return q;
    endfunction

    task automatic model_edge(input bit rst, input bit en, input bit iv, input int id,
                              input int tgt, input int md, input int fg);
        int nd, nc, a, dec, envn;
        new_out = 1'b0;
        if (rst) begin
            m_gain = 1 << FRAC; m_env = 0; m_hold = 0; m_state = 0;
            p1_v = 0; p1_d = 0; p1_m = 0;
            o_v = 0; o_d = 0; o_c = 0; o_m = 0;
        end else if (en) begin
            nd = o_d; nc = o_c;
            if (p1_v) begin
                if (p1_m == 0) begin
                    nd = p1_d; nc = 0;
                end else begin
                    nd = floor_scaled(p1_d, m_gain);
                    nc = 0;
                    if (nd > SMAX) begin nd = SMAX; nc = 1; end
                    if (nd < SMIN) begin nd = SMIN; nc = 1; end
                end
            end
            if (o_v) begin
                a    = (o_d < 0) ? -o_d : o_d;
                dec  = m_env - m_env / (1 << ENV_SHIFT);
                envn = (a > dec) ? a : dec;
                m_env = envn;
                if (o_m == 1) begin
                    m_gain = fg;
                end else if (o_m >= 2) begin
                    if (envn > tgt) begin
                        m_hold = HOLD_LEN; m_state = 1;
                        if (o_m == 2) m_gain = (m_gain - 1 < 1) ? 1 : m_gain - 1;
                    end else if (m_hold > 0) begin
                        m_hold--; m_state = 2;
                    end else if (envn < tgt - tgt / 8) begin
                        m_state = 3;
                        if (o_m == 2) m_gain = (m_gain + 1 > GMAX) ? GMAX : m_gain + 1;
                    end else begin
                        m_state = 0;
                    end
                end
            end
            if (p1_v) begin
                o_d = nd; o_c = nc; o_m = p1_m;
            end
            o_v = p1_v;
            new_out = p1_v;
            p1_v = iv;
            if (iv) begin p1_d = id; p1_m = md; end
        end
    endtask

    // One clock: sample inputs, advance model, compare every output after the edge
    task automatic tick();
        bit rst, en, iv;
        int id, tgt, md, fg;
        rst = reset; en = clk_enable; iv = bus.in_valid;
        id  = int'($signed(bus.in_data));
        tgt = int'(bus.target); md = int'(bus.mode); fg = int'(bus.fixed_gain);
        @(posedge clk);
        model_edge(rst, en, iv, id, tgt, md, fg);
        #1;
        check("out_valid", int'(bus.out_valid), int'(o_v));
        check("out_data", int'($signed(bus.out_data)), o_d);
        check("clipped", int'(bus.clipped), o_c);
        check("gain", int'(bus.gain), m_gain);
        check("agc_state", int'(bus.agc_state), m_state);
        if (new_out) begin
            out_log.push_back(int'($signed(bus.out_data)));
            clip_log.push_back(int'(bus.clipped));
        end
    endtask

    task automatic send(input int d, input int md);
        bus.in_valid = 1'b1;
        bus.in_data  = DATA_W'(d);
        bus.mode     = 2'(md);
        tick();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic prime_gain(input int g);
        bus.fixed_gain = GAIN_W'(g);
        send(0, 1);
        idle(2);
    endtask

    initial begin
        int g0, st, nv;
        int exp_fix[4];
        int exp_clip[4];
        int exp_byp[3];
        exp_fix  = '{100, 127, -128, -6};
        exp_clip = '{0, 1, 1, 0};
        exp_byp  = '{-128, 0, 127};

        reset = 1'b1; clk_enable = 1'b1;
        bus.in_valid = 1'($urandom); bus.in_data = DATA_W'($urandom);
        bus.target = DATA_W'($urandom); bus.mode = 2'($urandom);
        bus.fixed_gain = GAIN_W'($urandom);
        tick(); tick();
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.target = DATA_W'(40);
        idle(1);
        check("rst_gain", int'(bus.gain), 16);
        check("rst_state", int'(bus.agc_state), 0);
        check("rst_out_data", int'(bus.out_data), 0);

        // Bypass
        out_log.delete(); clip_log.delete();
        for (int i = 0; i < 3; i++) send(exp_byp[i], 0);
        idle(3);
        check("byp_count", out_log.size(), 3);
        if (out_log.size() == 3)
            for (int i = 0; i < 3; i++) begin
                check("byp_data", out_log[i], exp_byp[i]);
                check("byp_clip", clip_log[i], 0);
            end
        check("byp_gain", int'(bus.gain), 16);

        // Fixed gain 32
        prime_gain(32);
        check("fix_gain_loaded", int'(bus.gain), 32);
        out_log.delete(); clip_log.delete();
        for (int i = 0; i < 4; i++) send(exp_byp[0] == 0 ? 0 : (i == 0 ? 50 : i == 1 ? 100 : i == 2 ? -100 : -3), 1);
        idle(3);
        check("fix_count", out_log.size(), 4);
        if (out_log.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check("fix_data", out_log[i], exp_fix[i]);
                check("fix_clip", clip_log[i], exp_clip[i]);
            end

        // Gain of zero
        prime_gain(0);
        out_log.delete(); clip_log.delete();
        send(-128, 1);
        idle(2);
        check("g0_count", out_log.size(), 1);
        if (out_log.size() == 1) begin
            check("g0_data", out_log[0], 0);
            check("g0_clip", clip_log[0], 0);
        end

        // Attack, hold, release
        prime_gain(16);
        bus.target = DATA_W'(40);
        for (int i = 0; i < 30; i++) send(100, 2);
        check("attack_gain_dropped", int'(int'(bus.gain) < 16), 1);
        for (int i = 0; i < 80; i++) send(2, 2);
        idle(2);

        // Gain ceiling
        prime_gain(253);
        bus.target = DATA_W'(127);
        for (int i = 0; i < 40; i++) send(0, 2);
        idle(2);
        check("gain_ceiling", int'(bus.gain), 255);

        // Gain floor
        prime_gain(2);
        bus.target = DATA_W'(0);
        for (int i = 0; i < 10; i++) send(127, 2);
        idle(2);
        check("gain_floor", int'(bus.gain), 1);

        // Enable freeze mid-stream
        prime_gain(16);
        bus.target = DATA_W'(40);
        for (int i = 0; i < 4; i++) send(90, 2);
        g0 = int'(bus.gain);
        clk_enable = 1'b0;
        for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 255)) - 128, 2 + (i & 1));
        check("freeze_gain", int'(bus.gain), g0);
        clk_enable = 1'b1;
        for (int i = 0; i < 4; i++) send(90, 2);
        idle(3);

        // Auto-frozen under attack
        prime_gain(16);
        for (int i = 0; i < 5; i++) send(100, 2);
        send(100, 3); send(100, 3);
        g0 = int'(bus.gain);
        for (int i = 0; i < 10; i++) send(100, 3);
        check("frozen_gain", int'(bus.gain), g0);
        st = int'(bus.agc_state);
        check("frozen_state", int'(st == 1 || st == 2), 1);

        // Reset with samples in flight
        send(77, 1);
        reset = 1'b1;
        send(55, 1);
        reset = 1'b0;
        nv = 0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nv += int'(bus.out_valid);
        end
        check("rst_flight_valid", nv, 0);
        check("rst_flight_gain", int'(bus.gain), 16);

        // Randomised stream
        for (int i = 0; i < 3000; i++) begin
            if (i % 60 == 0) begin
                bus.mode       = 2'($urandom);
                bus.target     = DATA_W'($urandom_range(0, 140));
                bus.fixed_gain = ($urandom_range(0, 7) == 0) ? GAIN_W'(0) : GAIN_W'($urandom);
            end
            reset        = ($urandom_range(0, 399) == 0);
            clk_enable   = ($urandom_range(0, 7) != 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = DATA_W'($urandom);
            if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom);
            tick();
        end
        reset = 1'b0; clk_enable = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
